// File: rtl/axi4l_master_engine.sv
// rtl/axi4l_master_engine.sv - single-outstanding AXI4-Lite master driven by a valid/ready command port
module axi4l_master_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      RSP_WRITE,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                RSP_RESP,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic                      M_BVALID,
  input  logic [1:0]                M_BRESP,
  output logic                      M_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_ARADDR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  input  logic                      M_RVALID,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  output logic                      M_RREADY,
  output logic                      BUSY,
  output logic [7:0]                ERR_CNT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state;

  // Commands are only taken in IDLE; held low during reset even though the state already reads IDLE
  assign CMD_READY = (state == IDLE) && !ARESET;
  assign BUSY      = (state != IDLE);

  // AW and W may each finish this edge or already be finished
  logic aw_clear;
  logic w_clear;
  assign aw_clear = !M_AWVALID || M_AWREADY;
  assign w_clear  = !M_WVALID  || M_WREADY;

  // Transaction sequencer: owns every registered bus and response output
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      M_AWADDR  <= '0;
      M_AWVALID <= 1'b0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARADDR  <= '0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_WRITE <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= 2'b00;
      ERR_CNT   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            if (CMD_WRITE) begin
              M_AWADDR  <= CMD_ADDR;
              M_WDATA   <= CMD_WDATA;
              M_WSTRB   <= CMD_WSTRB;
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              M_ARADDR  <= CMD_ADDR;
              M_ARVALID <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (M_AWVALID && M_AWREADY) M_AWVALID <= 1'b0;
          if (M_WVALID && M_WREADY)   M_WVALID  <= 1'b0;
          if (aw_clear && w_clear) begin
            M_BREADY <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_BVALID) begin
            M_BREADY  <= 1'b0;
            RSP_WRITE <= 1'b1;
            RSP_RDATA <= '0;
            RSP_RESP  <= M_BRESP;
            RSP_VALID <= 1'b1;
            if (M_BRESP[1] && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (M_RVALID) begin
            M_RREADY  <= 1'b0;
            RSP_WRITE <= 1'b0;
            RSP_RDATA <= M_RDATA;
            RSP_RESP  <= M_RRESP;
            RSP_VALID <= 1'b1;
            if (M_RRESP[1] && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_master_engine.sv
// tb/tb_axi4l_master_engine.sv - vector table, directed corners and randomized model check for axi4l_master_engine
module tb_axi4l_master_engine;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [31:0] CMD_WDATA = '0;
  logic [3:0]  CMD_WSTRB = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic        RSP_WRITE;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic [31:0] M_AWADDR;
  logic        M_AWVALID;
  logic        M_AWREADY = 1'b0;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WVALID;
  logic        M_WREADY = 1'b0;
  logic        M_BVALID = 1'b0;
  logic [1:0]  M_BRESP = 2'b00;
  logic        M_BREADY;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic        M_RVALID = 1'b0;
  logic [31:0] M_RDATA = '0;
  logic [1:0]  M_RRESP = 2'b00;
  logic        M_RREADY;
  logic        BUSY;
  logic [7:0]  ERR_CNT;

  always #5 ACLK = ~ACLK;

  axi4l_master_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BRESP(M_BRESP), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RREADY(M_RREADY),
    .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_rsp_k, exp_done_k;
    logic [31:0] exp_rdata;
    int          exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int err_model = 0;
  bit aborted = 1'b0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int aw, input int w, input int b,
                              input int ar, input int r, input int rd, input logic [1:0] resp,
                              input logic [31:0] rdata, input int ek, input int ed,
                              input logic [31:0] erd, input int ee);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r; v.rsp_dly = rd;
    v.resp = resp; v.rdata = rdata;
    v.exp_rsp_k = ek; v.exp_done_k = ed; v.exp_rdata = erd; v.exp_err = ee;
    return v;
  endfunction

  // Slave + response consumer for one transaction. Sample k is the cycle after edge k-1, edge 0 = accept.
  task automatic run_txn(input vec_t v, output int rsp_k, output int done_k, output int aw_n,
                         output int w_n, output int ar_n, output logic o_write,
                         output logic [31:0] o_rdata, output logic [1:0] o_resp, output int proto);
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int b_wait = 0, r_wait = 0, rsp_wait = 0, k;
    rsp_k = -1; done_k = -1; aw_n = 0; w_n = 0; ar_n = 0; proto = 0;
    o_write = 1'b0; o_rdata = '0; o_resp = 2'b00;
    if (!CMD_READY) proto++;
    CMD_VALID = 1'b1; CMD_WRITE = v.wr; CMD_ADDR = v.addr; CMD_WDATA = v.wdata; CMD_WSTRB = v.strb;
    @(posedge ACLK); #1; k = 1;
    while (k < 200) begin
      // garbage command traffic while busy must be ignored
      CMD_VALID = 1'($urandom); CMD_WRITE = 1'($urandom); CMD_ADDR = $urandom;
      CMD_WDATA = $urandom; CMD_WSTRB = 4'($urandom);
      if (CMD_READY) begin done_k = k; break; end
      if (!BUSY) proto++;
      if (M_AWVALID) begin aw_n++; if (M_AWADDR !== v.addr) proto++; end
      if (M_WVALID) begin w_n++; if (M_WDATA !== v.wdata || M_WSTRB !== v.strb) proto++; end
      if (M_ARVALID) begin ar_n++; if (M_ARADDR !== v.addr) proto++; end
      if (M_BREADY && !(v.wr && aw_done && w_done && !b_done)) proto++;
      if (M_RREADY && !(!v.wr && ar_done && !r_done)) proto++;
      if (v.wr && M_ARVALID) proto++;
      if (!v.wr && (M_AWVALID || M_WVALID)) proto++;
      if (RSP_VALID) begin
        if (rsp_k < 0) begin
          rsp_k = k; o_write = RSP_WRITE; o_rdata = RSP_RDATA; o_resp = RSP_RESP;
        end else if ({RSP_WRITE, RSP_RDATA, RSP_RESP} !== {o_write, o_rdata, o_resp}) proto++;
      end
      M_AWREADY = M_AWVALID && (aw_n - 1 >= v.aw_dly);
      M_WREADY  = M_WVALID  && (w_n - 1 >= v.w_dly);
      M_ARREADY = M_ARVALID && (ar_n - 1 >= v.ar_dly);
      b_hs = 1'b0; r_hs = 1'b0;
      if (v.wr) begin
        if (aw_done && w_done && !b_done) begin
          b_wait++; M_BVALID = (b_wait > v.b_dly); M_BRESP = v.resp;
          b_hs = M_BVALID && M_BREADY;
        end else M_BVALID = 1'b0;
        M_RVALID = 1'($urandom); M_RDATA = $urandom; M_RRESP = 2'b11;
      end else begin
        if (ar_done && !r_done) begin
          r_wait++; M_RVALID = (r_wait > v.r_dly); M_RDATA = M_RVALID ? v.rdata : $urandom;
          M_RRESP = v.resp; r_hs = M_RVALID && M_RREADY;
        end else M_RVALID = 1'b0;
        M_BVALID = 1'($urandom); M_BRESP = 2'b11;
      end
      if (RSP_VALID) begin rsp_wait++; RSP_READY = (rsp_wait > v.rsp_dly); end
      else RSP_READY = 1'b0;
      aw_hs = M_AWVALID && M_AWREADY; w_hs = M_WVALID && M_WREADY; ar_hs = M_ARVALID && M_ARREADY;
      @(posedge ACLK);
      if (aw_hs) aw_done = 1; if (w_hs) w_done = 1; if (ar_hs) ar_done = 1;
      if (b_hs) b_done = 1; if (r_hs) r_done = 1;
      #1; k++;
    end
    CMD_VALID = 1'b0; RSP_READY = 1'b0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
    M_BVALID = 1'b0; M_RVALID = 1'b0; M_BRESP = 2'b00; M_RRESP = 2'b00;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int rsp_k, done_k, aw_n, w_n, ar_n, proto;
    logic o_write; logic [31:0] o_rdata; logic [1:0] o_resp;
    if (aborted) return;
    run_txn(v, rsp_k, done_k, aw_n, w_n, ar_n, o_write, o_rdata, o_resp, proto);
    if (v.resp[1] && err_model < 255) err_model++;
    check({tag, "_done_cycle"}, done_k, v.exp_done_k);
    if (done_k < 0) begin aborted = 1'b1; return; end
    check({tag, "_rsp_cycle"}, rsp_k, v.exp_rsp_k);
    check({tag, "_rsp_write"}, o_write, v.wr);
    check({tag, "_rsp_rdata"}, o_rdata, v.exp_rdata);
    check({tag, "_rsp_resp"}, o_resp, v.resp);
    check({tag, "_err_cnt"}, ERR_CNT, v.exp_err);
    check({tag, "_aw_cycles"}, aw_n, v.wr ? v.aw_dly + 1 : 0);
    check({tag, "_w_cycles"}, w_n, v.wr ? v.w_dly + 1 : 0);
    check({tag, "_ar_cycles"}, ar_n, v.wr ? 0 : v.ar_dly + 1);
    check({tag, "_protocol"}, proto, 0);
  endtask

  // Reference model: latency and error count straight from the handshake rules
  function automatic vec_t rand_vec();
    vec_t v;
    int m;
    v.wr = 1'($urandom); v.addr = $urandom & 32'hFFFF_FFFC; v.wdata = $urandom;
    v.strb = 4'($urandom);
    v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3); v.b_dly = $urandom_range(0, 3);
    v.ar_dly = $urandom_range(0, 3); v.r_dly = $urandom_range(0, 3); v.rsp_dly = $urandom_range(0, 3);
    v.resp = 2'($urandom); v.rdata = $urandom;
    m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    v.exp_rsp_k = v.wr ? m + v.b_dly + 3 : v.ar_dly + v.r_dly + 3;
    v.exp_done_k = v.exp_rsp_k + v.rsp_dly + 1;
    v.exp_rdata = v.wr ? 32'h0 : v.rdata;
    v.exp_err = (v.resp[1] && err_model < 255) ? err_model + 1 : err_model;
    return v;
  endfunction

  initial begin
    //            wr  addr      wdata         strb aw w b ar r rd resp  rdata          rk dk erd           err
    vecs[0] = mk(1, 32'h04, 32'hA5,        4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        3, 4, 32'h0,        0);
    vecs[1] = mk(1, 32'h10, 32'h1234,      4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 32'h0,        6, 7, 32'h0,        0);
    vecs[2] = mk(0, 32'h08, 32'h0,         4'h0, 0, 0, 0, 2, 0, 0, 2'b00, 32'hFF,       5, 6, 32'hFF,       0);
    vecs[3] = mk(0, 32'h0C, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'b10, 32'hDEAD0001, 3, 4, 32'hDEAD0001, 1);
    vecs[4] = mk(1, 32'h14, 32'h7,         4'h1, 0, 0, 0, 0, 0, 0, 2'b11, 32'h0,        3, 4, 32'h0,        2);
    vecs[5] = mk(1, 32'h18, 32'h55,        4'hF, 0, 0, 0, 0, 0, 5, 2'b01, 32'h0,        3, 9, 32'h0,        2);
    vecs[6] = mk(0, 32'h20, 32'h0,         4'h0, 0, 2, 0, 0, 1, 0, 2'b00, 32'h0BADF00D, 4, 5, 32'h0BADF00D, 0);

    #1 ARESET = 1'b1;
    #2;
    check("reset_ctrl", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY, RSP_VALID, CMD_READY, BUSY}, 8'h00);
    check("reset_addr", {M_AWADDR, M_ARADDR}, 64'h0);
    check("reset_wdata", {M_WDATA, M_WSTRB}, 36'h0);
    check("reset_rsp", {RSP_WRITE, RSP_RDATA, RSP_RESP}, 35'h0);
    check("reset_err", ERR_CNT, 8'h00);
    repeat (2) @(posedge ACLK);
    #3 ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("idle_ready", {CMD_READY, BUSY}, 2'b10);

    for (int i = 0; i < 6; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted between clock edges while AW/W are pending
    if (!aborted) begin
      CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h40; CMD_WDATA = 32'h99; CMD_WSTRB = 4'hF;
      @(posedge ACLK); #1;
      CMD_VALID = 1'b0;
      check("midrst_pre_valids", {M_AWVALID, M_WVALID}, 2'b11);
      #3 ARESET = 1'b1;
      #1;
      check("midrst_valids", {M_AWVALID, M_WVALID, CMD_READY, BUSY}, 4'b0000);
      check("midrst_err", ERR_CNT, 8'h00);
      @(posedge ACLK); #3 ARESET = 1'b0;
      err_model = 0;
      @(posedge ACLK); #1;
      check("midrst_after", {CMD_READY, BUSY}, 2'b10);
      apply(vecs[6], "vec6");
    end

    for (int i = 0; i < 60; i++) apply(rand_vec(), $sformatf("rnd%0d", i));

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) begin
      vec_t v;
      v = mk(0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b10, 32'h1, 3, 4, 32'h1,
             (err_model < 255) ? err_model + 1 : 255);
      apply(v, $sformatf("sat%0d", i));
    end
    if (!aborted) check("sat_final", ERR_CNT, 8'hFF);
    apply(mk(1, 32'h34, 32'h1, 4'h1, 0, 0, 1, 0, 0, 0, 2'b11, 32'h0, 4, 5, 32'h0, 255), "sat_write");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
